// File: rtl/usb2_pkg.sv
// Shared USB 2.0 constants: PIDs, CRC16 parameters and the IN-transmit FSM encoding.
package usb2_pkg;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // Reflected polynomial; the residual is what a receiver sees after checking data + CRC.
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HS       = 4'd1,
    ST_PID      = 4'd2,
    ST_PAYLOAD  = 4'd3,
    ST_CRC_LO   = 4'd4,
    ST_CRC_HI   = 4'd5,
    ST_WAIT_ACK = 4'd6,
    ST_ARM      = 4'd7,
    ST_ARM_WAIT = 4'd8
  } state_e;

endpackage

// File: rtl/usb2_crc16.sv
// Byte-wide USB CRC16 accumulator (LSB-first, reflected). init has priority over en.
module usb2_crc16
  import usb2_pkg::*;
(
  input  logic        phy_clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC16_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge phy_clk) begin
    if (reset || init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_next(crc, data);
    end
  end

endmodule

// File: rtl/usb2_ep_in_tx.sv
// IN-token responder: streams PID, buffer payload and CRC16 to the tx byte path,
// then waits for the host ACK and releases the endpoint buffer via the arm handshake.
module usb2_ep_in_tx
  import usb2_pkg::*;
#(
  parameter int MAX_PKT      = 512,
  parameter int ACK_TIMEOUT  = 120,
  parameter int ARM_HOLD_MAX = 255
) (
  input  logic       phy_clk,
  input  logic       reset,
  input  logic       in_token,
  input  logic       ep_stall,
  output logic [8:0] buf_out_addr,
  input  logic [7:0] buf_out_q,
  input  logic [9:0] buf_out_len,
  input  logic       buf_out_hasdata,
  output logic       buf_out_arm,
  input  logic       buf_out_arm_ack,
  input  logic [1:0] data_toggle,
  output logic       data_toggle_act,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  input  logic       rx_ack,
  output logic       busy,
  output logic       err_arm,
  output state_e     dbg_state
);

  localparam logic [9:0] MAX_LEN  = 10'(MAX_PKT);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] ARM_LAST = 8'(ARM_HOLD_MAX - 1);

  state_e      state, state_n;
  logic [9:0]  plen, plen_n, idx, idx_n, idx_inc;
  logic [7:0]  cnt, cnt_n, hs_pid, hs_pid_n;
  logic        pid_odd, pid_odd_n, toggle_n, err_n;
  logic        accept, crc_init, crc_en;
  logic [15:0] crc;

  // Valid/ready: a byte transfers on a cycle where tx_valid and tx_ready are both high;
  // tx_data and tx_last are held while tx_valid is high and tx_ready is low.
  assign tx_valid  = (state == ST_HS) || (state == ST_PID) || (state == ST_PAYLOAD) ||
                     (state == ST_CRC_LO) || (state == ST_CRC_HI);
  assign accept    = tx_valid & tx_ready;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign idx_inc   = idx + {9'd0, accept};

  usb2_crc16 u_crc (
    .phy_clk (phy_clk),
    .reset   (reset),
    .init    (crc_init),
    .en      (crc_en),
    .data    (buf_out_q),
    .crc     (crc)
  );

  always_comb begin
    state_n      = state;
    plen_n       = plen;
    idx_n        = idx;
    cnt_n        = cnt;
    hs_pid_n     = hs_pid;
    pid_odd_n    = pid_odd;
    toggle_n     = 1'b0;
    err_n        = err_arm;
    tx_data      = 8'h00;
    tx_last      = 1'b0;
    buf_out_addr = 9'd0;
    buf_out_arm  = 1'b0;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_token) begin
          if (ep_stall) begin
            hs_pid_n = PID_STALL;
            state_n  = ST_HS;
          end else if (!buf_out_hasdata) begin
            hs_pid_n = PID_NAK;
            state_n  = ST_HS;
          end else begin
            plen_n    = (buf_out_len > MAX_LEN) ? MAX_LEN : buf_out_len;
            idx_n     = 10'd0;
            pid_odd_n = data_toggle[0];
            crc_init  = 1'b1;
            state_n   = ST_PID;
          end
        end
      end
      ST_HS: begin
        tx_data = hs_pid;
        tx_last = 1'b1;
        if (accept) state_n = ST_IDLE;
      end
      ST_PID: begin
        tx_data = pid_odd ? PID_DATA1 : PID_DATA0;
        if (accept) state_n = (plen == 10'd0) ? ST_CRC_LO : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        // Address runs one ahead on accept so the next byte arrives with no bubble.
        tx_data      = buf_out_q;
        buf_out_addr = idx_inc[8:0];
        if (accept) begin
          crc_en = 1'b1;
          idx_n  = idx_inc;
          if (idx == plen - 10'd1) state_n = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        tx_data = ~crc[7:0];
        if (accept) state_n = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        tx_data = ~crc[15:8];
        tx_last = 1'b1;
        if (accept) begin
          cnt_n   = 8'd0;
          state_n = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (rx_ack) begin
          toggle_n = 1'b1;
          cnt_n    = 8'd0;
          state_n  = ST_ARM;
        end else if (cnt == TMO_LAST) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_ARM: begin
        buf_out_arm = 1'b1;
        if (buf_out_arm_ack) begin
          state_n = ST_ARM_WAIT;
        end else if (cnt == ARM_LAST) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_ARM_WAIT: begin
        // Ack is multi-cycle; re-arming before it drops would release two buffers.
        if (!buf_out_arm_ack) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      plen            <= 10'd0;
      idx             <= 10'd0;
      cnt             <= 8'd0;
      hs_pid          <= 8'h00;
      pid_odd         <= 1'b0;
      data_toggle_act <= 1'b0;
      err_arm         <= 1'b0;
    end else begin
      state           <= state_n;
      plen            <= plen_n;
      idx             <= idx_n;
      cnt             <= cnt_n;
      hs_pid          <= hs_pid_n;
      pid_odd         <= pid_odd_n;
      data_toggle_act <= toggle_n;
      err_arm         <= err_n;
    end
  end

endmodule

// File: tb/tb_usb2_ep_in_tx.sv
// Bench for usb2_ep_in_tx: packet-level model of expected tx bytes, buffer and arm-ack models.
module tb_usb2_ep_in_tx;

  logic       phy_clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_token = 1'b0;
  logic       ep_stall = 1'b0;
  logic [8:0] buf_out_addr;
  logic [7:0] buf_out_q;
  logic [9:0] buf_out_len = 10'd0;
  logic       buf_out_hasdata = 1'b0;
  logic       buf_out_arm;
  logic       buf_out_arm_ack = 1'b0;
  logic [1:0] data_toggle = 2'd0;
  logic       data_toggle_act;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       tx_last;
  logic       rx_ack = 1'b0;
  logic       busy;
  logic       err_arm;
  logic [3:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];
  logic [7:0] mem[0:511];
  bit rdy_rand = 1'b0;
  bit ack_en = 1'b1;
  int toggle_cnt = 0, arm_rise_cnt = 0, arm_hi_cnt = 0, valid_cyc = 0;

  always #5 phy_clk = ~phy_clk;

  usb2_ep_in_tx dut (
    .phy_clk         (phy_clk),
    .reset           (reset),
    .in_token        (in_token),
    .ep_stall        (ep_stall),
    .buf_out_addr    (buf_out_addr),
    .buf_out_q       (buf_out_q),
    .buf_out_len     (buf_out_len),
    .buf_out_hasdata (buf_out_hasdata),
    .buf_out_arm     (buf_out_arm),
    .buf_out_arm_ack (buf_out_arm_ack),
    .data_toggle     (data_toggle),
    .data_toggle_act (data_toggle_act),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_last         (tx_last),
    .rx_ack          (rx_ack),
    .busy            (busy),
    .err_arm         (err_arm),
    .dbg_state       (dbg_state)
  );

  // Endpoint buffer: one-cycle read latency.
  always @(posedge phy_clk) buf_out_q <= mem[buf_out_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC16/USB over mem[0..n-1]; returns the complemented value that is sent.
  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ mem[i][b]) c = (c >> 1) ^ 16'hA001;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic push_packet(input bit stall, input bit hasdata, input int len, input bit tog);
    logic [15:0] c;
    int n;
    if (stall) exp_q.push_back({1'b1, 8'h1E});
    else if (!hasdata) exp_q.push_back({1'b1, 8'h5A});
    else begin
      n = (len > 512) ? 512 : len;
      exp_q.push_back({1'b0, tog ? 8'h4B : 8'hC3});
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, mem[i]});
      c = model_crc(n);
      exp_q.push_back({1'b0, c[7:0]});
      exp_q.push_back({1'b1, c[15:8]});
    end
  endtask

  task automatic send_token(input bit stall, input bit hasdata, input int len, input bit tog);
    @(posedge phy_clk); #2;
    ep_stall        = stall;
    buf_out_hasdata = hasdata;
    buf_out_len     = 10'(len);
    data_toggle     = {1'b0, tog};
    push_packet(stall, hasdata, len, tog);
    toggle_cnt = 0; arm_rise_cnt = 0; arm_hi_cnt = 0; valid_cyc = 0;
    in_token = 1'b1;
    @(posedge phy_clk); #2;
    in_token = 1'b0;
  endtask

  task automatic wait_tx_done(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge phy_clk); #1;
      k++;
    end
    check("tx_done_in_time", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      @(negedge phy_clk);
      if (busy) n++;
    end
    check("back_to_idle", 32'(busy), 32'd0);
  endtask

  task automatic send_ack();
    repeat (3) @(posedge phy_clk);
    #2 rx_ack = 1'b1;
    @(posedge phy_clk); #2;
    rx_ack = 1'b0;
  endtask

  initial forever begin
    @(posedge phy_clk); #2;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Endpoint side of the arm handshake: ack after a delay, held for several cycles.
  initial forever begin
    @(posedge phy_clk); #2;
    if (ack_en && buf_out_arm && !buf_out_arm_ack) begin
      repeat (3) @(posedge phy_clk);
      #2 buf_out_arm_ack = 1'b1;
      repeat (3) @(posedge phy_clk);
      #2 buf_out_arm_ack = 1'b0;
    end
  end

  // Compare process: every transferred byte against the model queue, plus stall stability.
  initial begin
    logic       prev_stall, prev_arm;
    logic [7:0] prev_data;
    logic [8:0] e;
    prev_stall = 1'b0; prev_arm = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge phy_clk);
      if (!reset) begin
        if (data_toggle_act) toggle_cnt++;
        if (buf_out_arm && !prev_arm) arm_rise_cnt++;
        if (buf_out_arm) arm_hi_cnt++;
        if (tx_valid) valid_cyc++;
        if (prev_stall) check("stall_hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_data}));
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected none", {tx_last, tx_data});
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'({tx_last, tx_data}), 32'(e));
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_arm   = buf_out_arm;
      end else begin
        prev_stall = 1'b0;
        prev_arm   = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    string s;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;

    repeat (3) @(posedge phy_clk);
    @(negedge phy_clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_arm", 32'(err_arm), 32'd0);
    check("rst_arm", 32'(buf_out_arm), 32'd0);
    check("rst_toggle_act", 32'(data_toggle_act), 32'd0);
    check("rst_addr", 32'(buf_out_addr), 32'd0);
    @(posedge phy_clk); #2 reset = 1'b0;

    // Pin the reference CRC with the CRC-16/USB check value and the empty packet.
    s = "123456789";
    for (int i = 0; i < 9; i++) mem[i] = s[i];
    check("model_crc_check_str", 32'(model_crc(9)), 32'hB4C8);
    check("model_crc_empty", 32'(model_crc(0)), 32'h0000);

    // NAK when no data is committed.
    send_token(1'b0, 1'b0, 4, 1'b0);
    wait_tx_done(20);
    wait_idle(20, n);
    check("nak_idle_cycles", 32'(n), 32'd0);
    check("nak_valid_cycles", 32'(valid_cyc), 32'd1);
    check("nak_no_toggle", 32'(toggle_cnt), 32'd0);
    check("nak_no_arm", 32'(arm_rise_cnt), 32'd0);

    // Four-byte packet, DATA0, no bubbles, then ACK and arm.
    for (int i = 0; i < 4; i++) mem[i] = 8'(i);
    send_token(1'b0, 1'b1, 4, 1'b0);
    wait_tx_done(50);
    check("len4_valid_cycles", 32'(valid_cyc), 32'd7);
    send_ack();
    wait_idle(100, n);
    check("len4_toggle", 32'(toggle_cnt), 32'd1);
    check("len4_arm_rise", 32'(arm_rise_cnt), 32'd1);
    check("len4_arm_held", 32'(arm_hi_cnt >= 3), 32'd1);
    check("len4_err", 32'(err_arm), 32'd0);

    // Zero-length packet, DATA1: 4B 00 00.
    exp_q.push_back({1'b0, 8'h4B});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    send_token(1'b0, 1'b1, 0, 1'b1);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h4B});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    wait_tx_done(50);
    send_ack();
    wait_idle(100, n);
    check("zlp_toggle", 32'(toggle_cnt), 32'd1);

    // Check string payload under DATA1: expect ... C8 B4.
    for (int i = 0; i < 9; i++) mem[i] = s[i];
    send_token(1'b0, 1'b1, 9, 1'b1);
    wait_tx_done(50);
    send_ack();
    wait_idle(100, n);
    check("str_toggle", 32'(toggle_cnt), 32'd1);

    // Oversized buffer clamps to 512 bytes; random backpressure.
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
    rdy_rand = 1'b1;
    send_token(1'b0, 1'b1, 600, 1'b0);
    wait_tx_done(5000);
    rdy_rand = 1'b0;
    send_ack();
    wait_idle(100, n);
    check("big_toggle", 32'(toggle_cnt), 32'd1);
    check("big_arm_rise", 32'(arm_rise_cnt), 32'd1);

    // No handshake: timeout, buffer retained, identical retransmission.
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom_range(0, 255));
    send_token(1'b0, 1'b1, 4, 1'b1);
    wait_tx_done(50);
    wait_idle(300, n);
    check("tmo_cycles", 32'(n), 32'd120);
    check("tmo_no_toggle", 32'(toggle_cnt), 32'd0);
    check("tmo_no_arm", 32'(arm_rise_cnt), 32'd0);
    send_token(1'b0, 1'b1, 4, 1'b1);
    wait_tx_done(50);
    wait_idle(300, n);
    check("retry_tmo_cycles", 32'(n), 32'd120);

    // STALL overrides committed data.
    send_token(1'b1, 1'b1, 4, 1'b0);
    wait_tx_done(20);
    wait_idle(20, n);
    check("stall_valid_cycles", 32'(valid_cyc), 32'd1);
    check("stall_no_arm", 32'(arm_rise_cnt), 32'd0);

    // Arm acknowledgement never arrives: sticky error after the hold window.
    ack_en = 1'b0;
    send_token(1'b0, 1'b1, 2, 1'b0);
    wait_tx_done(50);
    send_ack();
    wait_idle(600, n);
    ack_en = 1'b1;
    check("armto_err", 32'(err_arm), 32'd1);
    check("armto_hold_cycles", 32'(arm_hi_cnt), 32'd255);
    check("armto_toggle", 32'(toggle_cnt), 32'd1);
    send_token(1'b0, 1'b0, 0, 1'b0);
    wait_tx_done(20);
    wait_idle(20, n);
    check("armto_err_sticky", 32'(err_arm), 32'd1);

    // Reset in the middle of the payload aborts at once.
    send_token(1'b0, 1'b1, 600, 1'b0);
    repeat (20) @(posedge phy_clk);
    #2 reset = 1'b1;
    @(posedge phy_clk);
    @(negedge phy_clk);
    check("rstmid_tx_valid", 32'(tx_valid), 32'd0);
    check("rstmid_tx_last", 32'(tx_last), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_err_clear", 32'(err_arm), 32'd0);
    exp_q.delete();
    @(posedge phy_clk); #2 reset = 1'b0;
    repeat (10) @(negedge phy_clk);
    check("rstmid_no_toggle", 32'(toggle_cnt), 32'd0);
    check("rstmid_no_arm", 32'(arm_rise_cnt), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb2_ep_in_tx.md
Name: usb2_ep_in_tx

Overview:
Protocol-side reader for the double-buffered USB 2.0 endpoint store. When the packet layer decodes an IN token addressed to this endpoint, the block reads the armed buffer, streams PID + payload + CRC16 to the transmit byte path, and waits for the host handshake. On ACK it advances the data toggle and arms the endpoint so the buffer is released back to the writer side. It runs in the phy_clk domain and sits between the endpoint buffer and the ULPI transmit mux.

Parameters:
MAX_PKT, 512, maximum payload bytes per packet; a larger buffer length is clamped to this value.
ACK_TIMEOUT, 120, phy_clk cycles to wait for a handshake after the last CRC byte is accepted.
ARM_HOLD_MAX, 255, cycles to hold buf_out_arm waiting for buf_out_arm_ack before flagging an error.

Ports:
phy_clk  in  1  sole clock (60 MHz ULPI clock).
reset  in  1  synchronous, active-high reset.
in_token  in  1  one-cycle pulse: IN token for this endpoint decoded.
ep_stall  in  1  level: endpoint halted; answer with STALL.
buf_out_addr  out  9  endpoint buffer read address; 1-cycle read latency.
buf_out_q  in  8  endpoint buffer read data.
buf_out_len  in  10  byte count of the current buffer.
buf_out_hasdata  in  1  current buffer holds a committed packet.
buf_out_arm  out  1  level request to release the current buffer.
buf_out_arm_ack  in  1  endpoint acknowledges arm (multi-cycle).
data_toggle  in  2  current toggle (0 = DATA0, 1 = DATA1).
data_toggle_act  out  1  one-cycle pulse: advance the toggle.
tx_data  out  8  transmit byte.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  downstream accepts the byte when it is high with tx_valid.
tx_last  out  1  marks the final byte of the packet.
rx_ack  in  1  one-cycle pulse: host ACK received.
busy  out  1  high in every state other than IDLE.
err_arm  out  1  sticky: arm ack timed out; cleared by reset.

Behaviour:
- Reset: state IDLE. buf_out_addr=0, buf_out_arm=0, data_toggle_act=0, tx_valid=0, tx_last=0, tx_data=0, busy=0, err_arm=0. Reset mid-packet aborts immediately. tx_valid drops on the cycle after the reset edge, with no tx_last.
- PIDs: DATA0 0xC3, DATA1 0x4B, NAK 0x5A, STALL 0x1E.
- IDLE → on in_token:
  - ep_stall=1 → HS, byte STALL.
  - else buf_out_hasdata=0 → HS, byte NAK.
  - else → PID; latch plen = min(buf_out_len, MAX_PKT); idx=0; crc=0xFFFF.
  - in_token is ignored outside IDLE.
- HS: tx_data = handshake PID, tx_valid=1, tx_last=1. On accept → IDLE.
- PID: tx_data = DATA0 or DATA1 per data_toggle[0] (value sampled at token). On accept → PAYLOAD, or CRC_LO if plen=0.
- PAYLOAD (zero-bubble):
  - tx_data = buf_out_q (combinational). buf_out_addr = idx + (tx_valid & tx_ready), combinational, so the next byte's q is valid one cycle later.
  - In PID, buf_out_addr=0 to prefetch byte 0.
  - On each accept: crc updated with the byte; idx++. After the byte with idx=plen-1 → CRC_LO.
- CRC16: reflected polynomial 0xA001, LSB-first, init 0xFFFF. Transmit ~crc, low byte (CRC_LO) then high byte (CRC_HI). tx_last=1 on CRC_HI.
- WAIT_ACK: starts after CRC_HI is accepted. tmo counter starts at 0.
  - rx_ack → data_toggle_act pulses 1 cycle; → ARM.
  - tmo reaches ACK_TIMEOUT-1 without ack → IDLE; no toggle, no arm; the buffer is retained for retry.
  - rx_ack and the timeout in the same cycle → ack wins.
- ARM: buf_out_arm=1.
  - buf_out_arm_ack seen → drop arm; → ARM_WAIT.
  - ARM_HOLD_MAX cycles without ack → drop arm, set err_arm, → IDLE.
- ARM_WAIT: wait for buf_out_arm_ack=0 → IDLE. This prevents a double arm on the multi-cycle ack.
- tx_valid stays high from PID until CRC_HI is accepted. tx_data is stable while tx_valid=1 and tx_ready=0.
- Backpressure: tx_ready=0 holds idx and buf_out_addr constant.
- Widths: idx and plen are 10 bits. buf_out_addr = idx[8:0]; idx never exceeds 511 in PAYLOAD.

Decomposition:
- Package usb2_pkg: PID constants (DATA0, DATA1, ACK, NAK, STALL), CRC16 polynomial/init/residual constants, FSM state encoding.
- One sub-module, usb2_crc16: byte-wide combinational next-CRC function plus a registered accumulator with init and enable inputs. Reused by the receive path.

Test Plan:
- hasdata=0, in_token → exactly one byte 0x5A with tx_last=1; no arm, no toggle; back to IDLE.
- Armed buffer, len=4, bytes 00 01 02 03, toggle=0, tx_ready=1 → C3 00 01 02 03 then the CRC byte pair matching the reference model, 7 cycles with no bubble; rx_ack → one toggle_act pulse; arm held until ack.
- len=0, toggle=1 → 4B 00 00 (zero-length packet CRC).
- len=600 → exactly 512 payload bytes at addresses 0..511; random tx_ready stalls keep the byte order and CRC correct.
- No rx_ack → IDLE after 120 cycles; a second in_token retransmits the identical packet with the same PID.
- ep_stall=1 with hasdata=1 → single byte 0x1E. Reset asserted mid-PAYLOAD → tx_valid=0 the next cycle, and arm/toggle_act are never asserted.
